synth_frame_sequencer: RTL and testbench
========================================

Name: synth_frame_sequencer

Overview:
Master controller for the synth voice-operator pipeline. It splits time into fixed sample frames and issues one voice-operator ID per cycle (256 slots per frame). It pulses the sample-ready strobe once the last slot writes back. Host register writes are buffered in a FIFO and applied to the configuration RAMs only in the idle write window at the end of each frame, so the pipeline never reads a RAM while it is being written.

Parameters:
NUM_SLOTS, 256, voice-operator slots issued per frame (8 ops x 32 voices); power of two.
FRAME_CYCLES, 1024, clock cycles per output sample frame; must be >= NUM_SLOTS+PIPE_LATENCY+1.
PIPE_LATENCY, 6, cycles from slot issue to its writeback at the subsample accumulator.
FIFO_DEPTH, 8, host register-write buffer entries; power of two, >= 2.

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  synchronous, active-high reset
i_Enable  in  1  run request; frames start only while high
i_RegisterWriteEnable  in  1  host write strobe
i_RegisterWriteNumber  in  16  host register number (SS PPPPPP OOO VVVVV scheme)
i_RegisterWriteValue  in  8  host write data
o_RegisterWriteReady  out  1  FIFO can accept a write this cycle
o_VoiceOperator  out  8  slot ID issued this cycle
o_VoiceOperatorValid  out  1  o_VoiceOperator is a live slot
o_FrameStart  out  1  one-cycle pulse coincident with slot 0
o_SampleReady  out  1  one-cycle pulse when slot NUM_SLOTS-1 writes back
o_ConfigWriteEnable  out  1  apply write to config RAMs this cycle
o_ConfigWriteNumber  out  16  register number being applied
o_ConfigWriteValue  out  8  data being applied

Behaviour:
- Clock and reset: one clock, i_Clock. i_Reset is synchronous and active-high.
- Reset state: all outputs 0 except o_RegisterWriteReady=1. FIFO is emptied, cycle counter = 0, state = IDLE. Reset asserted mid-frame aborts the frame immediately and discards FIFO contents. No o_SampleReady is produced for an aborted frame.
- States: IDLE, RUN, DRAIN, WINDOW. Cycle counter C is clog2(FRAME_CYCLES) bits.
- IDLE:
  - No slots are issued.
  - FIFO pops one entry per cycle to the o_Config* outputs (IDLE is a permanent write window).
  - If i_Enable=1, the next cycle enters RUN with C=0.
- RUN, C=0..NUM_SLOTS-1:
  - o_VoiceOperatorValid=1, o_VoiceOperator=C[7:0]. o_FrameStart=1 when C=0.
  - No FIFO pops. At C=NUM_SLOTS-1, go to DRAIN.
- DRAIN, C=NUM_SLOTS..NUM_SLOTS+PIPE_LATENCY-1:
  - Valid=0, no pops.
  - o_SampleReady=1 exactly at C=NUM_SLOTS-1+PIPE_LATENCY. This cycle may fall in RUN's last cycle when PIPE_LATENCY=0; PIPE_LATENCY >= 1 is required.
- WINDOW, C=NUM_SLOTS+PIPE_LATENCY..FRAME_CYCLES-1:
  - At most one FIFO pop per cycle while the FIFO is non-empty.
  - At C=FRAME_CYCLES-1: if i_Enable=1, the next cycle is RUN with C=0 (frames are back-to-back with no gap). Otherwise go to IDLE.
  - i_Enable is sampled only here and in IDLE. Dropping it mid-frame completes the frame.
- Config write outputs:
  - o_Config* are registered: popped entry appears the cycle after the pop decision.
  - o_ConfigWriteEnable=0 when nothing is popped; Number and Value hold their last values.
  - A pop decided at C=FRAME_CYCLES-1 is still presented in the following cycle (RUN C=0). To prevent this, the last pop is at C=FRAME_CYCLES-2, so no config write ever coincides with a valid slot.
- FIFO:
  - o_RegisterWriteReady = (count < FIFO_DEPTH), computed from registered count only.
  - A push at full is refused even if a pop occurs in the same cycle. The host must hold its write until ready.
  - Simultaneous push and pop when not full: count unchanged, order preserved (strict FIFO).
  - A push into an empty FIFO is poppable no earlier than the next cycle.
- Slot ID wraps NUM_SLOTS-1 -> 0 only via a new frame; C never exceeds FRAME_CYCLES-1.

Optional Feature:
SYNTH_SEQ_STATUS_EN
- Defined: adds ports o_FrameCount (out, 16) and o_WriteRefused (out, 1).
  - o_FrameCount increments on each o_SampleReady and wraps 0xFFFF -> 0.
  - o_WriteRefused is sticky; it sets when i_RegisterWriteEnable=1 while o_RegisterWriteReady=0.
  - Both clear only on i_Reset.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
(Parameters NUM_SLOTS=256, FRAME_CYCLES=300, PIPE_LATENCY=4, FIFO_DEPTH=8.)
1. Reset, then i_Enable=1 held -> o_FrameStart every 300 cycles; o_VoiceOperator 0..255 with Valid=1 for 256 consecutive cycles; o_SampleReady exactly at C=259; no Valid during C=256..299.
2. Push 3 writes (0xC005/0x11, 0xC105/0x22, 0x8003/0x33) during RUN -> o_ConfigWriteEnable is 0 until the window, then fires on 3 consecutive cycles starting C=261, in push order, with exact data.
3. Push 9 writes back-to-back during RUN -> ready drops after the 8th; the 9th is held by the bench and accepted once the window pops begin; all 9 are applied, none ever with Valid=1.
4. i_Enable=0 at C=100 -> frame completes (SampleReady at C=259), then IDLE; a write pushed in IDLE appears on o_Config* 2 cycles after the push.
5. Assert i_Reset at C=150 with 5 FIFO entries -> next cycle all outputs 0, ready=1; the 5 entries are never applied; no o_SampleReady.
6. SYNTH_SEQ_STATUS_EN defined: run 3 frames and attempt one push while full -> o_FrameCount=3, o_WriteRefused=1 until reset.

Source files
------------

// File: rtl/synth_frame_sequencer_if.sv
// Host-write, slot-issue and config-apply signals of synth_frame_sequencer.
// Optional status signals are present when SYNTH_SEQ_STATUS_EN is defined.
interface synth_frame_sequencer_if;
    // Host writes: a write transfers on a clock edge where i_RegisterWriteEnable and
    // o_RegisterWriteReady are both 1; the host holds number/value stable until then.
    logic        i_Enable;
    logic        i_RegisterWriteEnable;
    logic [15:0] i_RegisterWriteNumber;
    logic [7:0]  i_RegisterWriteValue;
    logic        o_RegisterWriteReady;
    logic [7:0]  o_VoiceOperator;
    logic        o_VoiceOperatorValid;
    logic        o_FrameStart;
    logic        o_SampleReady;
    logic        o_ConfigWriteEnable;
    logic [15:0] o_ConfigWriteNumber;
    logic [7:0]  o_ConfigWriteValue;
    logic [1:0]  o_DebugState;
`ifdef SYNTH_SEQ_STATUS_EN
    logic [15:0] o_FrameCount;
    logic        o_WriteRefused;
`endif

    modport master (
`ifdef SYNTH_SEQ_STATUS_EN
        output o_FrameCount, output o_WriteRefused,
`endif
        input  i_Enable, input i_RegisterWriteEnable,
        input  i_RegisterWriteNumber, input i_RegisterWriteValue,
        output o_RegisterWriteReady, output o_VoiceOperator, output o_VoiceOperatorValid,
        output o_FrameStart, output o_SampleReady, output o_ConfigWriteEnable,
        output o_ConfigWriteNumber, output o_ConfigWriteValue, output o_DebugState
    );

    modport slave (
`ifdef SYNTH_SEQ_STATUS_EN
        input  o_FrameCount, input o_WriteRefused,
`endif
        output i_Enable, output i_RegisterWriteEnable,
        output i_RegisterWriteNumber, output i_RegisterWriteValue,
        input  o_RegisterWriteReady, input o_VoiceOperator, input o_VoiceOperatorValid,
        input  o_FrameStart, input o_SampleReady, input o_ConfigWriteEnable,
        input  o_ConfigWriteNumber, input o_ConfigWriteValue, input o_DebugState
    );
endinterface

// File: rtl/synth_frame_sequencer.sv
// Frame sequencer: issues NUM_SLOTS slot IDs per frame, then applies FIFO-buffered host
// writes only in the end-of-frame window. Macro SYNTH_SEQ_STATUS_EN adds frame/refusal status.
module synth_frame_sequencer #(
    parameter int NUM_SLOTS    = 256,
    parameter int FRAME_CYCLES = 1024,
    parameter int PIPE_LATENCY = 6,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    synth_frame_sequencer_if.master bus
);
    localparam int CW = $clog2(FRAME_CYCLES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam logic [CW-1:0] C_RUN_LAST   = CW'(NUM_SLOTS - 1);
    localparam logic [CW-1:0] C_SAMPLE     = CW'(NUM_SLOTS + PIPE_LATENCY - 1);
    localparam logic [CW-1:0] C_FRAME_LAST = CW'(FRAME_CYCLES - 1);
    localparam logic [NW-1:0] FIFO_FULL    = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_WINDOW} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] c_q, c_d;
    logic [23:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic          ready, push, pop, pop_window;
    logic          valid_q, valid_d, fs_q, fs_d, sr_q, sr_d, cfg_we_q, cfg_we_d;
    logic [7:0]    slot_q, slot_d, cfg_val_q, cfg_val_d;
    logic [15:0]   cfg_num_q, cfg_num_d;
`ifdef SYNTH_SEQ_STATUS_EN
    logic [15:0]   fc_q, fc_d;
    logic          refused_q, refused_d;
`endif

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE: begin
                c_d = '0;
                if (bus.i_Enable) state_d = S_RUN;
            end
            S_RUN: begin
                c_d = c_q + 1'b1;
                if (c_q == C_RUN_LAST) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                c_d = c_q + 1'b1;
                if (c_q == C_SAMPLE) state_d = S_WINDOW;
            end
            S_WINDOW: begin
                if (c_q == C_FRAME_LAST) begin
                    c_d     = '0;
                    state_d = bus.i_Enable ? S_RUN : S_IDLE;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                c_d     = '0;
            end
        endcase

        // No pop on the last frame cycle or when leaving IDLE: its registered write would
        // land on slot 0 of the next frame.
        pop_window = ((state_q == S_IDLE) && !bus.i_Enable) ||
                     ((state_q == S_WINDOW) && (c_q != C_FRAME_LAST));
        ready = (count_q < FIFO_FULL);
        push  = bus.i_RegisterWriteEnable && ready;
        pop   = pop_window && (count_q != '0);

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        valid_d   = (state_d == S_RUN);
        slot_d    = valid_d ? 8'(c_d) : 8'd0;
        fs_d      = valid_d && (c_d == '0);
        sr_d      = (state_d == S_DRAIN) && (c_d == C_SAMPLE);
        cfg_we_d  = pop;
        cfg_num_d = pop ? mem_q[rd_ptr_q][23:8] : cfg_num_q;
        cfg_val_d = pop ? mem_q[rd_ptr_q][7:0]  : cfg_val_q;
`ifdef SYNTH_SEQ_STATUS_EN
        fc_d      = sr_d ? fc_q + 1'b1 : fc_q;
        refused_d = refused_q || (bus.i_RegisterWriteEnable && !ready);
`endif
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            c_q       <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            slot_q    <= '0;
            fs_q      <= 1'b0;
            sr_q      <= 1'b0;
            cfg_we_q  <= 1'b0;
            cfg_num_q <= '0;
            cfg_val_q <= '0;
`ifdef SYNTH_SEQ_STATUS_EN
            fc_q      <= '0;
            refused_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            slot_q    <= slot_d;
            fs_q      <= fs_d;
            sr_q      <= sr_d;
            cfg_we_q  <= cfg_we_d;
            cfg_num_q <= cfg_num_d;
            cfg_val_q <= cfg_val_d;
`ifdef SYNTH_SEQ_STATUS_EN
            fc_q      <= fc_d;
            refused_q <= refused_d;
`endif
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push) mem_q[wr_ptr_q] <= {bus.i_RegisterWriteNumber, bus.i_RegisterWriteValue};
    end

    assign bus.o_RegisterWriteReady = ready;
    assign bus.o_VoiceOperator      = slot_q;
    assign bus.o_VoiceOperatorValid = valid_q;
    assign bus.o_FrameStart         = fs_q;
    assign bus.o_SampleReady        = sr_q;
    assign bus.o_ConfigWriteEnable  = cfg_we_q;
    assign bus.o_ConfigWriteNumber  = cfg_num_q;
    assign bus.o_ConfigWriteValue   = cfg_val_q;
    assign bus.o_DebugState         = state_q;
`ifdef SYNTH_SEQ_STATUS_EN
    assign bus.o_FrameCount         = fc_q;
    assign bus.o_WriteRefused       = refused_q;
`endif
endmodule

// File: tb/tb_synth_frame_sequencer.sv
// Self-checking bench for synth_frame_sequencer against a frame-position/queue reference model.
// Define SYNTH_SEQ_STATUS_EN to also cover o_FrameCount / o_WriteRefused.
`timescale 1ns/1ps
module tb_synth_frame_sequencer;
    localparam int NS    = 256;
    localparam int FC    = 300;
    localparam int PL    = 4;
    localparam int FD    = 8;
    localparam int C_SR  = NS - 1 + PL;
    localparam int C_WIN = NS + PL;
`ifdef SYNTH_SEQ_STATUS_EN
    localparam int OW = 56;
`else
    localparam int OW = 39;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc_n = 0;

    synth_frame_sequencer_if bus ();

    synth_frame_sequencer #(
        .NUM_SLOTS(NS), .FRAME_CYCLES(FC), .PIPE_LATENCY(PL), .FIFO_DEPTH(FD)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: frame position (-1 = idle) and a queue of pending writes.
    int          m_pos = -1;
    logic [23:0] m_q[$];
    logic        m_cwe = 1'b0;
    logic [15:0] m_cnum = '0;
    logic [7:0]  m_cval = '0;
    logic [15:0] m_fc = '0;
    logic        m_ref = 1'b0;
    logic        m_acc = 1'b0;

    function automatic void model_step();
        logic [23:0] e;
        bit rdy, pop;
        m_acc = 1'b0;
        if (rst) begin
            m_pos = -1; m_q.delete(); m_cwe = 0; m_cnum = '0; m_cval = '0; m_fc = '0; m_ref = 0;
            return;
        end
        rdy = (m_q.size() < FD);
        if (bus.i_RegisterWriteEnable && !rdy) m_ref = 1'b1;
        pop = (m_q.size() > 0) && ((m_pos < 0 && !bus.i_Enable) || (m_pos >= C_WIN && m_pos <= FC - 2));
        m_cwe = pop;
        if (pop) begin
            e = m_q.pop_front();
            m_cnum = e[23:8];
            m_cval = e[7:0];
        end
        if (bus.i_RegisterWriteEnable && rdy) begin
            m_q.push_back({bus.i_RegisterWriteNumber, bus.i_RegisterWriteValue});
            m_acc = 1'b1;
        end
        if (m_pos < 0 || m_pos == FC - 1) m_pos = bus.i_Enable ? 0 : -1;
        else m_pos++;
        if (m_pos == C_SR) m_fc++;
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        logic [38:0] b;
        logic [1:0]  st;
        logic        v;
        if (m_pos < 0) st = 2'd0;
        else if (m_pos < NS) st = 2'd1;
        else if (m_pos < C_WIN) st = 2'd2;
        else st = 2'd3;
        v = (m_pos >= 0) && (m_pos < NS);
        b = {st, v, (v ? 8'(m_pos) : 8'd0), (m_pos == 0), (m_pos == C_SR), (m_q.size() < FD),
             m_cwe, m_cnum, m_cval};
`ifdef SYNTH_SEQ_STATUS_EN
        return {b, m_fc, m_ref};
`else
        return b;
`endif
    endfunction

    function automatic logic [OW-1:0] dut_vec();
        logic [38:0] b;
        b = {bus.o_DebugState, bus.o_VoiceOperatorValid, bus.o_VoiceOperator, bus.o_FrameStart,
             bus.o_SampleReady, bus.o_RegisterWriteReady, bus.o_ConfigWriteEnable,
             bus.o_ConfigWriteNumber, bus.o_ConfigWriteValue};
`ifdef SYNTH_SEQ_STATUS_EN
        return {b, bus.o_FrameCount, bus.o_WriteRefused};
`else
        return b;
`endif
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        cyc_n++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_Enable = 1'b0;
        bus.i_RegisterWriteEnable = 1'b0;
        bus.i_RegisterWriteNumber = '0;
        bus.i_RegisterWriteValue = '0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_vec cyc=%0d actual=%h expected=%h", cyc_n, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (bus.o_RegisterWriteReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready actual=%b expected=1", bus.o_RegisterWriteReady);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL idle_vec cyc=%0d actual=%h expected=%h", cyc_n, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_frames();
        int last_fs = -1;
        int vcount = 0;
        int n_fs = 0;
        bus.i_Enable = 1'b1;
        for (int k = 0; k < 2 * FC + 5; k++) begin
            cyc();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL frames_vec cyc=%0d actual=%h expected=%h", cyc_n, dut_vec(), exp_vec());
            end
            if (bus.o_FrameStart === 1'b1) begin
                if (last_fs >= 0) begin
                    n_cmp++;
                    if ((cyc_n - last_fs) != FC || vcount != NS) begin
                        n_fail++;
                        $display("FAIL frame_period actual=%0d/%0d expected=%0d/%0d",
                                 cyc_n - last_fs, vcount, FC, NS);
                    end
                end
                last_fs = cyc_n;
                vcount = 0;
                n_fs++;
            end
            if (bus.o_VoiceOperatorValid === 1'b1) begin
                vcount++;
                n_cmp++;
                if (bus.o_VoiceOperator !== 8'(cyc_n - last_fs)) begin
                    n_fail++;
                    $display("FAIL slot_id actual=%0d expected=%0d", bus.o_VoiceOperator, cyc_n - last_fs);
                end
            end
            if (bus.o_SampleReady === 1'b1) begin
                n_cmp++;
                if ((cyc_n - last_fs) != C_SR) begin
                    n_fail++;
                    $display("FAIL sample_ready_pos actual=%0d expected=%0d", cyc_n - last_fs, C_SR);
                end
            end
        end
        n_cmp++;
        if (n_fs != 3) begin
            n_fail++;
            $display("FAIL frame_starts actual=%0d expected=3", n_fs);
        end
    endtask

    task automatic test_config_window();
        logic [15:0] nums [3] = '{16'hC005, 16'hC105, 16'h8003};
        logic [7:0]  vals [3] = '{8'h11, 8'h22, 8'h33};
        int idx = 0;
        int got = 0;
        for (int k = 0; k < 2 * FC; k++) begin
            bus.i_RegisterWriteEnable = 1'b0;
            if (m_pos >= 10 && m_pos < 13 && idx < 3) begin
                bus.i_RegisterWriteEnable = 1'b1;
                bus.i_RegisterWriteNumber = nums[idx];
                bus.i_RegisterWriteValue = vals[idx];
                idx++;
            end
            cyc();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL cfg_vec cyc=%0d actual=%h expected=%h", cyc_n, dut_vec(), exp_vec());
            end
            if (bus.o_ConfigWriteEnable === 1'b1 && got < 3) begin
                n_cmp++;
                if (m_pos != C_WIN + 1 + got ||
                    {bus.o_ConfigWriteNumber, bus.o_ConfigWriteValue} !== {nums[got], vals[got]}) begin
                    n_fail++;
                    $display("FAIL cfg_apply pos=%0d data=%h expected pos=%0d data=%h", m_pos,
                             {bus.o_ConfigWriteNumber, bus.o_ConfigWriteValue}, C_WIN + 1 + got,
                             {nums[got], vals[got]});
                end
                got++;
            end
        end
        bus.i_RegisterWriteEnable = 1'b0;
        n_cmp++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL cfg_count actual=%0d expected=3", got);
        end
    endtask

    task automatic test_fifo_full();
        logic [15:0] pn [9];
        logic [7:0]  pv [9];
        int pidx = 0;
        int got = 0;
        bit started = 0;
        for (int i = 0; i < 9; i++) begin
            pn[i] = 16'($urandom);
            pv[i] = 8'($urandom);
        end
        for (int k = 0; k < 2 * FC; k++) begin
            if (m_pos == 5) started = 1;
            bus.i_RegisterWriteEnable = started && (pidx < 9);
            if (pidx < 9) begin
                bus.i_RegisterWriteNumber = pn[pidx];
                bus.i_RegisterWriteValue = pv[pidx];
            end
            cyc();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL full_vec cyc=%0d actual=%h expected=%h", cyc_n, dut_vec(), exp_vec());
            end
            if (bus.i_RegisterWriteEnable && m_acc) begin
                pidx++;
                if (pidx == 8) begin
                    n_cmp++;
                    if (bus.o_RegisterWriteReady !== 1'b0) begin
                        n_fail++;
                        $display("FAIL full_ready actual=%b expected=0", bus.o_RegisterWriteReady);
                    end
                end
                if (pidx == 9) begin
                    n_cmp++;
                    if (m_pos != C_WIN + 2) begin
                        n_fail++;
                        $display("FAIL ninth_accept_pos actual=%0d expected=%0d", m_pos, C_WIN + 2);
                    end
                end
            end
            if (bus.o_ConfigWriteEnable === 1'b1) begin
                n_cmp++;
                if (bus.o_VoiceOperatorValid !== 1'b0 || got >= 9 ||
                    {bus.o_ConfigWriteNumber, bus.o_ConfigWriteValue} !== {pn[got % 9], pv[got % 9]}) begin
                    n_fail++;
                    $display("FAIL full_apply idx=%0d valid=%b data=%h expected=%h", got,
                             bus.o_VoiceOperatorValid, {bus.o_ConfigWriteNumber, bus.o_ConfigWriteValue},
                             {pn[got % 9], pv[got % 9]});
                end
                got++;
            end
        end
        bus.i_RegisterWriteEnable = 1'b0;
        n_cmp++;
        if (got != 9 || pidx != 9) begin
            n_fail++;
            $display("FAIL full_count applied=%0d pushed=%0d expected=9/9", got, pidx);
        end
    endtask

    task automatic test_enable_drop();
        bit dropped = 0;
        int n_sr = 0;
        int n_fs = 0;
        logic [23:0] w;
        for (int k = 0; k < 3 * FC; k++) begin
            if (m_pos == 100 && !dropped) begin
                bus.i_Enable = 1'b0;
                dropped = 1;
            end
            cyc();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL drop_vec cyc=%0d actual=%h expected=%h", cyc_n, dut_vec(), exp_vec());
            end
            if (dropped && bus.o_SampleReady === 1'b1) n_sr++;
            if (dropped && bus.o_FrameStart === 1'b1) n_fs++;
            if (dropped && m_pos < 0) break;
        end
        n_cmp++;
        if (n_sr != 1 || n_fs != 0 || m_pos >= 0) begin
            n_fail++;
            $display("FAIL drop_complete sr=%0d fs=%0d pos=%0d expected 1/0/-1", n_sr, n_fs, m_pos);
        end
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_cmp++;
            if (bus.o_VoiceOperatorValid !== 1'b0 || dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL idle_after_drop actual=%h expected=%h", dut_vec(), exp_vec());
            end
        end
        w = 24'($urandom);
        bus.i_RegisterWriteEnable = 1'b1;
        {bus.i_RegisterWriteNumber, bus.i_RegisterWriteValue} = w;
        cyc();
        bus.i_RegisterWriteEnable = 1'b0;
        n_cmp++;
        if (bus.o_ConfigWriteEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_cfg_early actual=%b expected=0", bus.o_ConfigWriteEnable);
        end
        cyc();
        n_cmp++;
        if ({bus.o_ConfigWriteEnable, bus.o_ConfigWriteNumber, bus.o_ConfigWriteValue} !== {1'b1, w}) begin
            n_fail++;
            $display("FAIL idle_cfg actual=%h expected=%h",
                     {bus.o_ConfigWriteEnable, bus.o_ConfigWriteNumber, bus.o_ConfigWriteValue}, {1'b1, w});
        end
    endtask

    task automatic test_reset_mid();
        bit did_rst = 0;
        int n_cwe = 0;
        int n_sr = 0;
        bus.i_Enable = 1'b1;
        for (int k = 0; k < 2 * FC; k++) begin
            bus.i_RegisterWriteEnable = (m_pos >= 20 && m_pos < 25);
            bus.i_RegisterWriteNumber = 16'($urandom);
            bus.i_RegisterWriteValue = 8'($urandom);
            if (m_pos == 150) rst = 1'b1;
            cyc();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rstmid_vec cyc=%0d actual=%h expected=%h", cyc_n, dut_vec(), exp_vec());
            end
            if (rst) begin
                did_rst = 1;
                break;
            end
        end
        rst = 1'b0;
        bus.i_Enable = 1'b0;
        bus.i_RegisterWriteEnable = 1'b0;
        n_cmp++;
        if (!did_rst || bus.o_RegisterWriteReady !== 1'b1 ||
            {bus.o_VoiceOperatorValid, bus.o_VoiceOperator, bus.o_FrameStart, bus.o_SampleReady,
             bus.o_ConfigWriteEnable, bus.o_ConfigWriteNumber, bus.o_ConfigWriteValue} !== 36'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs done=%0d actual=%h expected ready=1 rest=0", did_rst, dut_vec());
        end
        for (int k = 0; k < FC + 50; k++) begin
            cyc();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rstmid_idle cyc=%0d actual=%h expected=%h", cyc_n, dut_vec(), exp_vec());
            end
            if (bus.o_ConfigWriteEnable === 1'b1) n_cwe++;
            if (bus.o_SampleReady === 1'b1) n_sr++;
        end
        n_cmp++;
        if (n_cwe != 0 || n_sr != 0) begin
            n_fail++;
            $display("FAIL rstmid_discard cfg=%0d sr=%0d expected 0/0", n_cwe, n_sr);
        end
    endtask

    task automatic test_random();
        bit hold = 0;
        bus.i_Enable = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 149) == 0) bus.i_Enable = ~bus.i_Enable;
            rst = ($urandom_range(0, 1499) == 0);
            if (!hold && $urandom_range(0, 3) == 0) begin
                hold = 1;
                bus.i_RegisterWriteNumber = 16'($urandom);
                bus.i_RegisterWriteValue = 8'($urandom);
            end
            bus.i_RegisterWriteEnable = hold;
            cyc();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_vec cyc=%0d actual=%h expected=%h", cyc_n, dut_vec(), exp_vec());
            end
            if (bus.o_ConfigWriteEnable === 1'b1 && bus.o_VoiceOperatorValid === 1'b1) begin
                n_fail++;
                $display("FAIL random_cfg_overlap cyc=%0d actual=1 expected=0", cyc_n);
            end
            if (m_acc || rst) hold = 0;
        end
        rst = 1'b0;
        bus.i_RegisterWriteEnable = 1'b0;
    endtask

`ifdef SYNTH_SEQ_STATUS_EN
    task automatic test_status();
        int pidx = 0;
        int nf = 0;
        rst = 1'b1;
        bus.i_Enable = 1'b0;
        bus.i_RegisterWriteEnable = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        bus.i_Enable = 1'b1;
        for (int k = 0; k < 5 * FC; k++) begin
            bus.i_RegisterWriteEnable = (m_pos >= 5 && pidx < 9);
            bus.i_RegisterWriteNumber = 16'($urandom);
            bus.i_RegisterWriteValue = 8'($urandom);
            if (bus.i_RegisterWriteEnable) pidx++;
            if (nf == 3 && m_pos == 100) bus.i_Enable = 1'b0;
            cyc();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL status_vec cyc=%0d actual=%h expected=%h", cyc_n, dut_vec(), exp_vec());
            end
            if (m_pos == 0) nf++;
            if (!bus.i_Enable && m_pos < 0) break;
        end
        bus.i_RegisterWriteEnable = 1'b0;
        for (int k = 0; k < 10; k++) cyc();
        n_cmp++;
        if (bus.o_FrameCount !== 16'd3 || bus.o_WriteRefused !== 1'b1) begin
            n_fail++;
            $display("FAIL status_values count=%0d refused=%b expected 3/1", bus.o_FrameCount, bus.o_WriteRefused);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++;
        if (bus.o_FrameCount !== 16'd0 || bus.o_WriteRefused !== 1'b0) begin
            n_fail++;
            $display("FAIL status_reset count=%0d refused=%b expected 0/0", bus.o_FrameCount, bus.o_WriteRefused);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frames();
        test_config_window();
        test_fifo_full();
        test_enable_drop();
        test_reset_mid();
        test_random();
`ifdef SYNTH_SEQ_STATUS_EN
        test_status();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
